// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between two
// valid/ready requesters (round-robin) and a clear engine that zeroes every address.
// Ports: CLK100MHZ/rst_n (sync, active-low); clr_start/clr_busy/clr_done clear control;
// reqX_valid/addr/data/ready requester handshakes; rf_we/rf_addr/rf_data/rf_src registered write port.
module regfile_write_arbiter #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic         CLK100MHZ,
  input  logic         rst_n,
  input  logic         clr_start,
  output logic         clr_busy,
  output logic         clr_done,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_addr,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_addr,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         rf_we,
  output logic [N-1:0] rf_addr,
  output logic [W-1:0] rf_data,
  output logic [1:0]   rf_src
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic prio;
  logic [N-1:0] cnt;
  logic arb_en;
  always_comb begin
    arb_en = rst_n && state == IDLE && !clr_start;
    req0_ready = arb_en && req0_valid && (!req1_valid || !prio);
    req1_ready = arb_en && req1_valid && (!req0_valid || prio);
    clr_busy = state == CLEAR;
    state_nx = state == IDLE ? (clr_start ? CLEAR : IDLE) : (&cnt ? IDLE : CLEAR);
  end
  // cnt holds the address currently presented on rf_addr during a sweep
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state <= IDLE;
      prio <= 1'b0;
      cnt <= '0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      rf_src <= 2'd0;
      clr_done <= 1'b0;
    end else begin
      state <= state_nx;
      clr_done <= state == CLEAR && &cnt;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        rf_we <= !(&cnt);
        rf_addr <= cnt + 1'b1;
        rf_data <= '0;
        rf_src <= 2'd2;
      end else if (clr_start) begin
        cnt <= '0;
        rf_we <= 1'b1;
        rf_addr <= '0;
        rf_data <= '0;
        rf_src <= 2'd2;
      end else begin
        rf_we <= req0_ready || req1_ready;
        if (req0_ready || req1_ready) begin
          rf_addr <= req1_ready ? req1_addr : req0_addr;
          rf_data <= req1_ready ? req1_data : req0_data;
          rf_src <= {1'b0, req1_ready};
          prio <= req0_ready;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, clr_start, clr_busy, clr_done;
  logic v0, v1, req0_ready, req1_ready, rf_we;
  logic [2:0] a0, a1, rf_addr;
  logic [7:0] d0, d1, rf_data;
  logic [1:0] rf_src;
  logic [7:0] rf [8];
  int n_chk = 0, n_pass = 0;
  int m_turn = 0, m_issued = 0, e_addr = 0, e_data = 0, e_src = 0;
  bit m_active = 0, e_we = 0, e_busy = 0, e_done = 0, g0, g1, s_r0, s_r1, s_done;
  int mm [8];

  regfile_write_arbiter #(.N(3), .W(8)) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_src(rf_src)
  );

  always_ff @(posedge clk) if (rf_we) rf[rf_addr] <= rf_data;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic emit(input int a, input int d, input int s);
    e_we = 1; e_addr = a; e_data = d; e_src = s; mm[a] = d;
  endtask

  task automatic step(input bit r, input bit c, input bit q0, input int x0, input int y0,
                      input bit q1, input int x1, input int y1);
    rst_n = r; clr_start = c; v0 = q0; v1 = q1;
    a0 = 3'(x0); d0 = 8'(y0); a1 = 3'(x1); d1 = 8'(y1);
    #4;
    g0 = 0; g1 = 0;
    if (r && !m_active && !c) begin
      if (q0 && q1) begin g0 = (m_turn == 0); g1 = !g0; end
      else begin g0 = q0; g1 = q1; end
    end
    s_r0 = req0_ready; s_r1 = req1_ready; s_done = clr_done;
    chk("ready0", s_r0, g0);
    chk("ready1", s_r1, g1);
    @(posedge clk);
    e_done = 0;
    if (!r) begin
      m_active = 0; m_issued = 0; m_turn = 0; e_we = 0; e_busy = 0;
    end else if (m_active) begin
      if (m_issued == 8) begin m_active = 0; e_we = 0; e_busy = 0; e_done = 1; end
      else begin emit(m_issued, 0, 2); m_issued++; end
    end else if (c) begin
      m_active = 1; m_issued = 1; e_busy = 1; emit(0, 0, 2);
    end else if (g0) begin emit(x0, y0, 0); m_turn = 1; end
    else if (g1) begin emit(x1, y1, 1); m_turn = 0; end
    else e_we = 0;
    #1;
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_data", rf_data, e_data);
      chk("rf_src", rf_src, e_src);
    end
    chk("clr_busy", clr_busy, e_busy);
    chk("clr_done", clr_done, e_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit p0 = 0, p1 = 0;
    int pa0 = 0, pd0 = 0, pa1 = 0, pd1 = 0, bc, dc;
    for (int i = 0; i < 8; i++) mm[i] = 0;
    // reset with every input high
    for (int i = 0; i < 3; i++) step(0, 1, 1, 7, 255, 1, 7, 255);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_src", rf_src, 0);
    step(1, 0, 1, 3, 8'hA5, 0, 0, 0);
    chk("first_ready", s_r0, 1);
    chk("single_addr", rf_addr, 3);
    chk("single_data", rf_data, 8'hA5);
    chk("single_src", rf_src, 0);
    idle(1);
    chk("single_we_off", rf_we, 0);
    // contention from a fresh reset
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 1, 8'h11, 1, 2, 8'h22);
      chk("cont_grant0", s_r0, int'(k % 2 == 0));
      chk("cont_src", rf_src, k % 2);
    end
    idle(1);
    // preload 0xFF then clear sweep
    for (int i = 0; i < 8; i++) step(1, 0, 1, i, 8'hFF, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    bc = int'(clr_busy); dc = 0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      bc += int'(clr_busy); dc += int'(clr_done);
    end
    chk("sweep_busy_cycles", bc, 8);
    chk("sweep_done_pulses", dc, 1);
    for (int i = 0; i < 8; i++) chk("sweep_mem", rf[i], 0);
    // clear coinciding with a request
    for (int k = 0; k < 10; k++) begin
      step(1, k == 0, 0, 0, 0, 1, 5, 8'h3C);
      chk("cvr_ready1", s_r1, int'(k == 9));
      chk("cvr_done", s_done, int'(k == 9));
    end
    idle(2);
    chk("cvr_mem5", rf[5], 8'h3C);
    // reset during the fourth sweep write
    for (int i = 0; i < 8; i++) step(1, 0, 1, i, 8'hFF, 0, 0, 0);
    idle(1);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("mid_addr", rf_addr, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_we", rf_we, 0);
    chk("mid_busy", clr_busy, 0);
    idle(12);
    for (int i = 0; i < 8; i++) chk("mid_mem", rf[i], i < 4 ? 0 : 8'hFF);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (!p0 && $urandom_range(1) == 1) begin p0 = 1; pa0 = $urandom_range(7); pd0 = $urandom_range(255); end
      if (!p1 && $urandom_range(1) == 1) begin p1 = 1; pa1 = $urandom_range(7); pd1 = $urandom_range(255); end
      step($urandom_range(49) != 0, $urandom_range(29) == 0, p0, pa0, pd0, p1, pa1, pd1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    idle(12);
    for (int i = 0; i < 8; i++) chk("rand_mem", rf[i], mm[i]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
